kernel_cc_fifo_param: RTL and testbench

KERNEL_CC_FIFO_PARAM -- requirements
Module: kernel_cc_fifo_param

---
 rtl/kernel_cc_fifo_param_if.sv | 29 ++
 rtl/kernel_cc_fifo_param.sv | 100 ++++++++++
 tb/tb_kernel_cc_fifo_param.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/kernel_cc_fifo_param_if.sv
// Handshake bundle for kernel_cc_fifo_param: write side, read side and occupancy status.
interface kernel_cc_fifo_param_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
);
  logic                  if_write;
  logic                  if_write_ce;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_read;
  logic                  if_read_ce;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;
  logic [ADDR_WIDTH:0]   if_num_data_valid;
  logic                  if_almost_full_n;
  logic                  if_almost_empty_n;

  modport master (
    output if_write, if_write_ce, if_din, if_read, if_read_ce,
    input  if_full_n, if_dout, if_empty_n, if_num_data_valid,
           if_almost_full_n, if_almost_empty_n
  );

  modport slave (
    input  if_write, if_write_ce, if_din, if_read, if_read_ce,
    output if_full_n, if_dout, if_empty_n, if_num_data_valid,
           if_almost_full_n, if_almost_empty_n
  );
endinterface

// File: rtl/kernel_cc_fifo_param.sv
// Shift-register show-ahead FIFO with registered occupancy flags.
// Optional sticky overflow/underflow flags: define KERNEL_CC_FIFO_ERR_FLAGS_EN.
module kernel_cc_fifo_param #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 2,
  parameter int DEPTH         = 4,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  kernel_cc_fifo_param_if.slave   bus,
  output logic                    err_overflow,
  output logic                    err_underflow
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  wr_req;
  logic                  rd_req;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  full_n;
  logic                  empty_n;
  logic                  afull_n;
  logic                  aempty_n;

  assign wr_req = bus.if_write & bus.if_write_ce;
  assign rd_req = bus.if_read & bus.if_read_ce;
  // Gating by the flags gives read-only when full and write-only when empty.
  assign wr_acc = wr_req & full_n;
  assign rd_acc = rd_req & empty_n;

  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc)
      count_nxt = count + 1'b1;
    else if (rd_acc && !wr_acc)
      count_nxt = count - 1'b1;
  end

  // Flags are derived from the next occupancy so they line up with the count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count    <= '0;
      full_n   <= 1'b1;
      empty_n  <= 1'b0;
      afull_n  <= 1'b1;
      aempty_n <= 1'b0;
    end else begin
      count    <= count_nxt;
      full_n   <= (count_nxt != DEPTH_C);
      empty_n  <= (count_nxt != '0);
      afull_n  <= (count_nxt < AFULL_C);
      aempty_n <= (count_nxt > AEMPTY_C);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = DEPTH - 1; i > 0; i--)
        mem[i] <= mem[i-1];
      mem[0] <= bus.if_din;
    end
  end

  // Oldest entry sits at count-1; the low bits wrap correctly when count == DEPTH.
  assign rd_idx = count[ADDR_WIDTH-1:0] - 1'b1;

  assign bus.if_dout           = mem[rd_idx];
  assign bus.if_full_n         = full_n;
  assign bus.if_empty_n        = empty_n;
  assign bus.if_num_data_valid = count;
  assign bus.if_almost_full_n  = afull_n;
  assign bus.if_almost_empty_n = aempty_n;

`ifdef KERNEL_CC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (wr_req && !full_n)
        err_overflow <= 1'b1;
      if (rd_req && !empty_n)
        err_underflow <= 1'b1;
    end
  end
`else
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_kernel_cc_fifo_param.sv
// Drives a DEPTH=4 and a DEPTH=8 FIFO with identical stimulus and compares both
// against queue-based reference models.
module tb_kernel_cc_fifo_param;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  kernel_cc_fifo_param_if #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) if4 ();
  kernel_cc_fifo_param_if #(.DATA_WIDTH(64), .ADDR_WIDTH(3)) if8 ();
  logic ovf4, unf4, ovf8, unf8;

  kernel_cc_fifo_param dut4 (
    .clk(clk), .reset_n(reset_n), .bus(if4.slave),
    .err_overflow(ovf4), .err_underflow(unf4)
  );

  kernel_cc_fifo_param #(
    .DATA_WIDTH(64), .ADDR_WIDTH(3), .DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(2)
  ) dut8 (
    .clk(clk), .reset_n(reset_n), .bus(if8.slave),
    .err_overflow(ovf8), .err_underflow(unf8)
  );

  int errors = 0;
  int checks = 0;
  logic [63:0] q4[$];
  logic [63:0] q8[$];
  bit m_ovf4, m_unf4, m_ovf8, m_unf8;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] err_exp(input bit m);
`ifdef KERNEL_CC_FIFO_ERR_FLAGS_EN
    return {63'd0, m};
`else
    return 64'd0;
`endif
  endfunction

  task automatic model_edge(input bit rst, input bit wr, input bit rd, input logic [63:0] d);
    bit full, empty;
    if (!rst) begin
      q4.delete(); q8.delete();
      m_ovf4 = 0; m_unf4 = 0; m_ovf8 = 0; m_unf8 = 0;
    end else begin
      full = (q4.size() == 4); empty = (q4.size() == 0);
      if (wr && full) m_ovf4 = 1;
      if (rd && empty) m_unf4 = 1;
      if (rd && !empty) void'(q4.pop_front());
      if (wr && !full) q4.push_back(d);
      full = (q8.size() == 8); empty = (q8.size() == 0);
      if (wr && full) m_ovf8 = 1;
      if (rd && empty) m_unf8 = 1;
      if (rd && !empty) void'(q8.pop_front());
      if (wr && !full) q8.push_back(d);
    end
  endtask

  task automatic check_all();
    chk("cnt4", 64'(if4.if_num_data_valid), 64'(q4.size()));
    chk("empty_n4", 64'(if4.if_empty_n), 64'(q4.size() != 0));
    chk("full_n4", 64'(if4.if_full_n), 64'(q4.size() != 4));
    chk("afull_n4", 64'(if4.if_almost_full_n), 64'(q4.size() < 3));
    chk("aempty_n4", 64'(if4.if_almost_empty_n), 64'(q4.size() > 1));
    chk("ovf4", 64'(ovf4), err_exp(m_ovf4));
    chk("unf4", 64'(unf4), err_exp(m_unf4));
    if (q4.size() > 0) chk("dout4", if4.if_dout, q4[0]);
    chk("cnt8", 64'(if8.if_num_data_valid), 64'(q8.size()));
    chk("empty_n8", 64'(if8.if_empty_n), 64'(q8.size() != 0));
    chk("full_n8", 64'(if8.if_full_n), 64'(q8.size() != 8));
    chk("afull_n8", 64'(if8.if_almost_full_n), 64'(q8.size() < 6));
    chk("aempty_n8", 64'(if8.if_almost_empty_n), 64'(q8.size() > 2));
    chk("ovf8", 64'(ovf8), err_exp(m_ovf8));
    chk("unf8", 64'(unf8), err_exp(m_unf8));
    if (q8.size() > 0) chk("dout8", if8.if_dout, q8[0]);
  endtask

  task automatic step(input bit rst, input bit w, input bit wce,
                      input bit r, input bit rce, input logic [63:0] d);
    reset_n = rst;
    if4.if_write = w; if4.if_write_ce = wce; if4.if_read = r; if4.if_read_ce = rce; if4.if_din = d;
    if8.if_write = w; if8.if_write_ce = wce; if8.if_read = r; if8.if_read_ce = rce; if8.if_din = d;
    @(posedge clk);
    #1;
    model_edge(rst, w & wce, r & rce, d);
    check_all();
  endtask

  initial begin
    bit w, r, rst;
    int wpct;
    step(0, 0, 0, 0, 0, 64'h0);
    step(0, 1, 1, 1, 1, 64'hdead);
    chk("rst_cnt_const", 64'(if4.if_num_data_valid), 64'd0);

    // Fill DEPTH=4 with 1..4, then a refused 5th write.
    for (int i = 1; i <= 4; i++) step(1, 1, 1, 0, 0, 64'(i));
    chk("full4_const", 64'(if4.if_full_n), 64'd0);
    chk("dout4_const", if4.if_dout, 64'h1);
    step(1, 1, 1, 0, 0, 64'h5);
    chk("ovf_cnt_const", 64'(if4.if_num_data_valid), 64'd4);

    // Simultaneous read+write at count 2.
    step(0, 0, 0, 0, 0, 64'h0);
    step(1, 1, 1, 0, 0, 64'h1);
    step(1, 1, 1, 0, 0, 64'h2);
    step(1, 1, 1, 1, 1, 64'h9);
    chk("rw_dout_const", if4.if_dout, 64'h2);
    step(1, 0, 0, 1, 1, 64'h0);
    chk("rw_next_const", if4.if_dout, 64'h9);
    step(1, 0, 1, 1, 1, 64'h0);
    step(1, 1, 0, 1, 0, 64'h77);
    // Read from empty.
    step(1, 0, 0, 1, 1, 64'h0);
    step(1, 0, 0, 1, 1, 64'h0);

    // Reset for one cycle at count 3.
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 64'h30 + 64'(i));
    step(0, 1, 1, 0, 0, 64'h99);
    chk("rst_mid_const", 64'(if4.if_empty_n), 64'd0);

    // Fill 0->8 then drain 8->0 to walk the almost thresholds.
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0, 64'hA0 + 64'(i));
    for (int i = 0; i < 9; i++) step(1, 0, 0, 1, 1, 64'h0);

    // Randomized phases alternating write-heavy and read-heavy traffic.
    for (int i = 0; i < 600; i++) begin
      wpct = ((i / 50) % 2 == 0) ? 75 : 25;
      w = ($urandom_range(0, 99) < wpct);
      r = ($urandom_range(0, 99) >= wpct);
      rst = ($urandom_range(0, 79) != 0);
      step(rst, w, $urandom_range(0, 7) != 0, r, $urandom_range(0, 7) != 0,
           {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
